// File: rtl/pixel_histogram_engine.sv
// 256-bin histogram over a fixed-size frame of 8-bit pixels.
// Bins are cleared, accumulated, then streamed out one per handshake.
module pixel_histogram_engine #(
    parameter int PIKSEL_SAYISI = 76800,
    parameter int BIN_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [7:0]       veri_i,
    input  logic             veri_gecerli_i,
    output logic             veri_al_o,
    output logic [BIN_W-1:0] veri_o,
    output logic             veri_gonder_o,
    input  logic             veri_kabul_i,
    output logic [7:0]       bin_no_o,
    output logic             islem_bitti_o
);

    localparam int CNT_W = $clog2(PIKSEL_SAYISI + 1);

    localparam logic [1:0] BOSTA   = 2'd0;
    localparam logic [1:0] TEMIZLE = 2'd1;
    localparam logic [1:0] TOPLA   = 2'd2;
    localparam logic [1:0] GONDER  = 2'd3;

    localparam logic [CNT_W-1:0] TOPLAM     = CNT_W'(PIKSEL_SAYISI);
    localparam logic [CNT_W-1:0] SON_PIKSEL = CNT_W'(PIKSEL_SAYISI - 1);
    localparam logic [BIN_W-1:0] BIN_MAX    = '1;

    logic [1:0]       durum_q, durum_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] sayac_q, sayac_d;
    logic             bitti_q, bitti_d;

    logic [BIN_W-1:0] bin_q [256];

    logic             aktar;
    logic             kabul;
    logic             bin_we;
    logic [7:0]       bin_adr;
    logic [BIN_W-1:0] bin_wd;
    logic [BIN_W-1:0] bin_eski;

    assign veri_al_o     = (durum_q == TOPLA) && (sayac_q < TOPLAM);
    assign veri_gonder_o = (durum_q == GONDER);
    assign aktar         = veri_al_o & veri_gecerli_i;
    assign kabul         = veri_gonder_o & veri_kabul_i;
    assign veri_o        = veri_gonder_o ? bin_q[idx_q] : '0;
    assign bin_no_o      = veri_gonder_o ? idx_q : 8'd0;
    assign islem_bitti_o = bitti_q;

    // Array is written at the edge, so a repeated pixel next cycle
    // already reads the updated count: no forwarding needed.
    assign bin_eski = bin_q[veri_i];

    always_comb begin
        durum_d = durum_q;
        idx_d   = idx_q;
        sayac_d = sayac_q;
        bitti_d = 1'b0;
        bin_we  = 1'b0;
        bin_adr = veri_i;
        bin_wd  = (bin_eski == BIN_MAX) ? BIN_MAX
                                        : bin_eski + BIN_W'(1);
        case (durum_q)
            BOSTA: begin
                if (en_i) begin
                    durum_d = TEMIZLE;
                    idx_d   = 8'd0;
                    sayac_d = '0;
                end
            end
            TEMIZLE: begin
                bin_we  = 1'b1;
                bin_adr = idx_q;
                bin_wd  = '0;
                idx_d   = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    durum_d = TOPLA;
                    sayac_d = '0;
                end
            end
            TOPLA: begin
                if (aktar) begin
                    bin_we  = 1'b1;
                    sayac_d = sayac_q + CNT_W'(1);
                    if (sayac_q == SON_PIKSEL) begin
                        durum_d = GONDER;
                        idx_d   = 8'd0;
                    end
                end
            end
            GONDER: begin
                if (kabul) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        durum_d = BOSTA;
                        bitti_d = 1'b1;
                    end
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q <= BOSTA;
            idx_q   <= 8'd0;
            sayac_q <= '0;
            bitti_q <= 1'b0;
        end else begin
            durum_q <= durum_d;
            idx_q   <= idx_d;
            sayac_q <= sayac_d;
            bitti_q <= bitti_d;
        end
    end

    // Bin storage is left unreset; TEMIZLE clears it at frame start.
    always_ff @(posedge clk_i) begin
        if (bin_we) begin
            bin_q[bin_adr] <= bin_wd;
        end
    end

endmodule

// File: tb/tb_pixel_histogram_engine.sv
// Scoreboard bench for pixel_histogram_engine.
// Three instances cover N=16, N=256 and a 4-bit saturating variant.
module tb_pixel_histogram_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en    [3];
    logic       gec   [3];
    logic       kabul [3];
    logic [7:0] px    [3];
    logic       al    [3];
    logic       gon   [3];
    logic       bitti [3];
    logic [7:0] bno   [3];
    logic [31:0] vo   [3];
    logic [31:0] vo0, vo1;
    logic [3:0]  vo2;

    always_comb begin
        vo[0] = vo0;
        vo[1] = vo1;
        vo[2] = {28'd0, vo2};
    end

    pixel_histogram_engine #(.PIKSEL_SAYISI(16), .BIN_W(32)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .veri_i(px[0]),
        .veri_gecerli_i(gec[0]), .veri_al_o(al[0]), .veri_o(vo0),
        .veri_gonder_o(gon[0]), .veri_kabul_i(kabul[0]),
        .bin_no_o(bno[0]), .islem_bitti_o(bitti[0])
    );

    pixel_histogram_engine #(.PIKSEL_SAYISI(256), .BIN_W(32)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .veri_i(px[1]),
        .veri_gecerli_i(gec[1]), .veri_al_o(al[1]), .veri_o(vo1),
        .veri_gonder_o(gon[1]), .veri_kabul_i(kabul[1]),
        .bin_no_o(bno[1]), .islem_bitti_o(bitti[1])
    );

    pixel_histogram_engine #(.PIKSEL_SAYISI(20), .BIN_W(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .veri_i(px[2]),
        .veri_gecerli_i(gec[2]), .veri_al_o(al[2]), .veri_o(vo2),
        .veri_gonder_o(gon[2]), .veri_kabul_i(kabul[2]),
        .bin_no_o(bno[2]), .islem_bitti_o(bitti[2])
    );

    int checks = 0;
    int errors = 0;
    longint model [256];
    longint exp_q [$];
    logic [7:0] px_q [$];
    int hs [3] = '{0, 0, 0};

    always @(posedge clk) begin
        if (gon[0] && kabul[0]) hs[0] <= hs[0] + 1;
        if (gon[1] && kabul[1]) hs[1] <= hs[1] + 1;
        if (gon[2] && kabul[2]) hs[2] <= hs[2] + 1;
    end

    function automatic int nval(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 256 : 20);
    endfunction

    function automatic longint maxv(input int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    task automatic start_frame(input int k);
        for (int b = 0; b < 256; b++) model[b] = 0;
        @(negedge clk);
        en[k] = 1'b1;
    endtask

    task automatic send(input int k, input int toggle,
                        input int en_mid, input int full);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (i < px_q.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            en[k] = (en_mid != 0) && (i == nval(k) / 2);
            ph = (toggle != 0) ? ~ph : 1'b1;
            gec[k] = ph;
            px[k] = px_q[i];
            if (gec[k] && al[k]) begin
                if (model[px_q[i]] >= maxv(k)) model[px_q[i]] = maxv(k);
                else model[px_q[i]] = model[px_q[i]] + 1;
                i++;
            end
        end
        @(negedge clk);
        gec[k] = 1'b0;
        en[k] = 1'b0;
        checks++;
        if (i != px_q.size()) begin
            errors++;
            $display("FAIL send_timeout k=%0d sent %0d want %0d",
                     k, i, px_q.size());
        end
        if (full != 0) begin
            checks++;
            if (al[k] !== 1'b0 || gon[k] !== 1'b1) begin
                errors++;
                $display("FAIL gonder_entry k=%0d al=%b gon=%b want 0/1",
                         k, al[k], gon[k]);
            end
        end
    endtask

    task automatic push_exp();
        exp_q.delete();
        for (int b = 0; b < 256; b++) exp_q.push_back(model[b]);
    endtask

    task automatic collect(input int k, input int stall, input int poke);
        int base = hs[k];
        longint e;
        logic [31:0] v0;
        for (int b = 0; b < 256; b++) begin
            int g = 0;
            while (!gon[k] && g < 1000) begin
                @(negedge clk);
                g++;
            end
            if (!gon[k]) begin
                checks++;
                errors++;
                $display("FAIL gonder_timeout k=%0d bin %0d", k, b);
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if (vo[k] !== e[31:0] || bno[k] !== b[7:0]) begin
                errors++;
                $display("FAIL bin k=%0d got %0d/%0d want %0d/%0d",
                         k, bno[k], vo[k], b, e);
            end
            en[k] = (poke != 0) && (b >= 10) && (b < 13);
            gec[k] = (poke != 0) && (b < 200);
            px[k] = 8'hFF;
            if (stall != 0) begin
                kabul[k] = 1'b0;
                v0 = vo[k];
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (vo[k] !== v0 || bno[k] !== b[7:0] || gon[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_stable k=%0d got %0d/%0d want %0d/%0d",
                                 k, bno[k], vo[k], b, v0);
                    end
                end
            end
            kabul[k] = 1'b1;
            @(negedge clk);
        end
        en[k] = 1'b0;
        gec[k] = 1'b0;
        checks++;
        if (bitti[k] !== 1'b1) begin
            errors++;
            $display("FAIL bitti_pulse k=%0d got %b want 1", k, bitti[k]);
        end
        checks++;
        if (hs[k] - base != 256) begin
            errors++;
            $display("FAIL handshakes k=%0d got %0d want 256", k, hs[k] - base);
        end
        kabul[k] = 1'b0;
        @(negedge clk);
        checks++;
        if (bitti[k] !== 1'b0 || gon[k] !== 1'b0 || al[k] !== 1'b0) begin
            errors++;
            $display("FAIL bitti_end k=%0d bitti=%b gon=%b al=%b want 0/0/0",
                     k, bitti[k], gon[k], al[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (al[k] !== 1'b0 || gon[k] !== 1'b0 || bitti[k] !== 1'b0 ||
                vo[k] !== 32'd0 || bno[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset k=%0d al=%b gon=%b bitti=%b vo=%0d bno=%0d want zeros",
                         k, al[k], gon[k], bitti[k], vo[k], bno[k]);
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (al[k] !== 1'b0 || gon[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle k=%0d al=%b gon=%b want 0/0", k, al[k], gon[k]);
            end
        end
    endtask

    task automatic test_single_value();
        px_q.delete();
        repeat (16) px_q.push_back(8'h05);
        start_frame(0);
        send(0, 0, 1, 1);
        push_exp();
        collect(0, 0, 1);
    endtask

    task automatic test_ramp();
        px_q.delete();
        for (int i = 0; i < 256; i++) px_q.push_back(8'(i));
        start_frame(1);
        send(1, 0, 0, 1);
        push_exp();
        collect(1, 0, 0);
    endtask

    task automatic test_stall();
        px_q.delete();
        for (int i = 0; i < 16; i++) px_q.push_back(8'($urandom_range(0, 4) * 60));
        start_frame(0);
        send(0, 1, 0, 1);
        push_exp();
        collect(0, 1, 0);
    endtask

    task automatic test_abort();
        px_q.delete();
        repeat (8) px_q.push_back(8'h33);
        start_frame(0);
        send(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (al[0] !== 1'b0 || gon[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset al=%b gon=%b want 0/0", al[0], gon[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bitti[0] !== 1'b0 || al[0] !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle bitti=%b al=%b want 0/0", bitti[0], al[0]);
            end
        end
        px_q.delete();
        repeat (16) px_q.push_back(8'hFF);
        start_frame(0);
        send(0, 0, 0, 1);
        push_exp();
        collect(0, 0, 0);
    endtask

    task automatic test_saturate();
        px_q.delete();
        repeat (20) px_q.push_back(8'h00);
        start_frame(2);
        send(2, 0, 0, 1);
        push_exp();
        collect(2, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0;
            gec[k] = 1'b0;
            kabul[k] = 1'b0;
            px[k] = 8'd0;
        end
        test_reset();
        test_single_value();
        test_ramp();
        test_stall();
        test_abort();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_histogram_engine.md
PIXEL_HISTOGRAM_ENGINE -- requirements
Module: pixel_histogram_engine

Interface
REQ-001 SHALL have parameter PIKSEL_SAYISI, default 76800, number of 8-bit pixels per frame.
REQ-002 SHALL have parameter BIN_W, default 32, width of each histogram bin.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  start pulse; starts a frame when idle.
REQ-006 SHALL have port veri_i  input  8  pixel value.
REQ-007 SHALL have port veri_gecerli_i  input  1  pixel valid.
REQ-008 SHALL have port veri_al_o  output  1  ready to accept a pixel.
REQ-009 SHALL have port veri_o  output  BIN_W  current bin count.
REQ-010 SHALL have port veri_gonder_o  output  1  veri_o valid.
REQ-011 SHALL have port veri_kabul_i  input  1  consumer accepts veri_o.
REQ-012 SHALL have port bin_no_o  output  8  index of bin on veri_o.
REQ-013 SHALL have port islem_bitti_o  output  1  one-cycle pulse after last bin accepted.

Function
REQ-014 SHALL implement FSM states BOSTA, TEMIZLE, TOPLA, GONDER.
REQ-015 BOSTA: en_i=1 SHALL move to TEMIZLE; otherwise stay; en_i SHALL be ignored in all other states.
REQ-016 TEMIZLE SHALL zero bins 0..255, one bin per cycle (256 cycles), then enter TOPLA with pixel counter = 0.
REQ-017 TOPLA: veri_al_o SHALL be 1 (combinationally from state) while pixel counter < PIKSEL_SAYISI.
REQ-018 A pixel SHALL transfer on a cycle with veri_gecerli_i=1 and veri_al_o=1; bin[veri_i] increments by 1 the following edge; pixel counter increments.
REQ-019 Back-to-back transfers, including identical values on consecutive cycles, SHALL each be counted (one pixel per cycle sustained, no lost increments).
REQ-020 Bin increment SHALL saturate at 2^BIN_W-1 (no wrap).
REQ-021 When the PIKSEL_SAYISI-th pixel transfers, SHALL enter GONDER the next cycle with bin index 0; veri_al_o SHALL be 0 from that cycle.
REQ-022 GONDER: veri_gonder_o=1, veri_o=bin[bin_no_o]; veri_o and bin_no_o SHALL stay stable until veri_gonder_o & veri_kabul_i.
REQ-023 On each accept, bin_no_o SHALL advance by 1; on accept of bin 255, SHALL return to BOSTA and assert islem_bitti_o for exactly one cycle.
REQ-024 veri_kabul_i while veri_gonder_o=0 SHALL have no effect.
REQ-025 veri_gecerli_i while veri_al_o=0 SHALL be ignored (pixel not counted).
REQ-026 Sum of all 256 bins at GONDER entry SHALL equal PIKSEL_SAYISI.

Reset
REQ-027 rst_ni=0 SHALL immediately (asynchronously) force BOSTA; veri_al_o=0, veri_gonder_o=0, islem_bitti_o=0, veri_o=0, bin_no_o=0, pixel counter=0.
REQ-028 Reset mid-TOPLA or mid-GONDER SHALL abandon the frame; no islem_bitti_o pulse; next frame starts from TEMIZLE on en_i.
REQ-029 Bin contents need not reset; TEMIZLE SHALL guarantee a clean frame.

Verification
REQ-030 PIKSEL_SAYISI=16, en_i pulse, 16 pixels all 0x05 back-to-back, veri_kabul_i=1 -> bin 5 = 16, all other bins 0, islem_bitti_o one cycle after bin 255 accepted.
REQ-031 PIKSEL_SAYISI=256, pixels 0..255 once each -> every bin = 1; exactly 256 valid/accept handshakes.
REQ-032 Pixels with veri_gecerli_i toggling 1/0 and veri_kabul_i stalled 3 cycles per bin -> counts unchanged vs. unstalled run; veri_o/bin_no_o stable during stalls.
REQ-033 Reset asserted after 8 of 16 pixels, then en_i and full 16-pixel frame of 0xFF -> bin 255 = 16, bin values from aborted frame absent.
REQ-034 en_i pulsed during TOPLA and GONDER -> no state change; veri_gecerli_i=1 during TEMIZLE and GONDER -> no count.
REQ-035 BIN_W=4, 20 pixels of 0x00 -> bin 0 = 15 (saturated).
